// File: rtl/hangman_datapath.sv
// Datapath for a five-letter hangman game: word ROM, guessed-letter register,
// per-position match, revealed mask, tries counter, word pointer and result flags.
module hangman_datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] char_in,
    input  logic       en_input_char,
    input  logic       en_word_index,
    input  logic       s_guessed_letters,
    input  logic       en_guessed_letters,
    input  logic       s_tries,
    input  logic       en_tries,
    input  logic       s_win,
    input  logic       en_win,
    input  logic       s_lose,
    input  logic       en_lose,
    output logic [4:0] input_char_eq_word,
    output logic       guessed_letters_is_done,
    output logic [4:0] guessed_mask,
    output logic [2:0] tries_left,
    output logic       tries_zero,
    output logic [2:0] word_index,
    output logic       win,
    output logic       lose
);

    localparam int unsigned CHAR_W     = 5;
    localparam int unsigned WORD_LEN   = 5;
    localparam int unsigned WORD_W     = CHAR_W * WORD_LEN;
    localparam int unsigned TRIES_W    = 3;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NUM_LETTER = 26;

    localparam logic [CHAR_W-1:0]  CHAR_IDLE  = 5'h1F;
    localparam logic [TRIES_W-1:0] TRIES_INIT = 3'd6;

    localparam logic [CHAR_W-1:0] L_A = 5'd0;
    localparam logic [CHAR_W-1:0] L_C = 5'd2;
    localparam logic [CHAR_W-1:0] L_D = 5'd3;
    localparam logic [CHAR_W-1:0] L_E = 5'd4;
    localparam logic [CHAR_W-1:0] L_F = 5'd5;
    localparam logic [CHAR_W-1:0] L_G = 5'd6;
    localparam logic [CHAR_W-1:0] L_H = 5'd7;
    localparam logic [CHAR_W-1:0] L_I = 5'd8;
    localparam logic [CHAR_W-1:0] L_K = 5'd10;
    localparam logic [CHAR_W-1:0] L_L = 5'd11;
    localparam logic [CHAR_W-1:0] L_O = 5'd14;
    localparam logic [CHAR_W-1:0] L_P = 5'd15;
    localparam logic [CHAR_W-1:0] L_R = 5'd17;
    localparam logic [CHAR_W-1:0] L_S = 5'd18;
    localparam logic [CHAR_W-1:0] L_T = 5'd19;
    localparam logic [CHAR_W-1:0] L_W = 5'd22;

    // Words are packed last letter in the MSBs so letter i sits at [i*5 +: 5]
    localparam logic [WORD_W-1:0] W_CHIPS = {L_S, L_P, L_I, L_H, L_C};
    localparam logic [WORD_W-1:0] W_LOGIC = {L_C, L_I, L_G, L_O, L_L};
    localparam logic [WORD_W-1:0] W_GATES = {L_S, L_E, L_T, L_A, L_G};
    localparam logic [WORD_W-1:0] W_ADDER = {L_R, L_E, L_D, L_D, L_A};
    localparam logic [WORD_W-1:0] W_FLOPS = {L_S, L_P, L_O, L_L, L_F};
    localparam logic [WORD_W-1:0] W_CLOCK = {L_K, L_C, L_O, L_L, L_C};
    localparam logic [WORD_W-1:0] W_WIRES = {L_S, L_E, L_R, L_I, L_W};
    localparam logic [WORD_W-1:0] W_RESET = {L_T, L_E, L_S, L_E, L_R};

    logic [CHAR_W-1:0]   input_char_q;
    logic [WORD_W-1:0]   cur_word;
    logic [WORD_LEN-1:0] match;
    logic                char_valid;

    // Word ROM
    always_comb begin
        cur_word = W_CHIPS;
        case (word_index)
            3'd0:    cur_word = W_CHIPS;
            3'd1:    cur_word = W_LOGIC;
            3'd2:    cur_word = W_GATES;
            3'd3:    cur_word = W_ADDER;
            3'd4:    cur_word = W_FLOPS;
            3'd5:    cur_word = W_CLOCK;
            3'd6:    cur_word = W_WIRES;
            3'd7:    cur_word = W_RESET;
            default: cur_word = W_CHIPS;
        endcase
    end

    // Per-position compare; the idle/invalid codes never match
    always_comb begin
        match      = '0;
        char_valid = (input_char_q < CHAR_W'(NUM_LETTER));
        for (int i = 0; i < int'(WORD_LEN); i++) begin
            match[i] = char_valid && (cur_word[i*CHAR_W +: CHAR_W] == input_char_q);
        end
    end

    assign input_char_eq_word      = match;
    assign guessed_letters_is_done = (guessed_mask == {WORD_LEN{1'b1}});
    assign tries_zero              = (tries_left == '0);

    // All registers update independently from pre-edge values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            input_char_q <= CHAR_IDLE;
            guessed_mask <= '0;
            tries_left   <= TRIES_INIT;
            word_index   <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            if (en_input_char) begin
                input_char_q <= char_in;
            end
            if (en_guessed_letters) begin
                guessed_mask <= s_guessed_letters ? (guessed_mask | match) : '0;
            end
            if (en_tries) begin
                if (s_tries) begin
                    tries_left <= TRIES_INIT;
                end else if (tries_left != '0) begin
                    tries_left <= tries_left - TRIES_W'(1);
                end
            end
            if (en_word_index) begin
                word_index <= word_index + IDX_W'(1);
            end
            if (en_win) begin
                win <= s_win;
            end
            if (en_lose) begin
                lose <= s_lose;
            end
        end
    end

endmodule

// File: doc/hangman_datapath.md
HANGMAN_DATAPATH -- requirements
Module: hangman_datapath

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- char_in  in  5  guessed letter code, A=0..Z=25; codes 26-31 are invalid
- en_input_char  in  1  load char_in into the input-char register
- en_word_index  in  1  advance to the next word (new game)
- s_guessed_letters  in  1  1 = OR the current match into the mask; 0 = clear the mask
- en_guessed_letters  in  1  write the guessed mask
- s_tries  in  1  1 = load tries with 6; 0 = decrement tries
- en_tries  in  1  write the tries counter
- s_win, en_win  in  1,1  win flag data and write enable
- s_lose, en_lose  in  1,1  lose flag data and write enable
- input_char_eq_word  out  5  per-position match of the input-char register against the word; bit0 = first letter
- guessed_letters_is_done  out  1  guessed mask is all ones
- guessed_mask  out  5  positions revealed so far
- tries_left  out  3  remaining wrong guesses
- tries_zero  out  1  tries_left == 0
- word_index  out  3  current word number
- win, lose  out  1,1  registered game-result flags

Function
REQ-003 The block SHALL hold an internal 8-entry word ROM of five letters each, listed first letter first: 0 CHIPS, 1 LOGIC, 2 GATES, 3 ADDER, 4 FLOPS, 5 CLOCK, 6 WIRES, 7 RESET.
REQ-004 On en_input_char=1, the input-char register SHALL load char_in at the clock edge; char_in SHALL be ignored otherwise.
REQ-005 input_char_eq_word[i] SHALL be combinational: 1 when the input-char register equals letter i of ROM[word_index]; it is valid the cycle after the load edge.
REQ-006 An input-char value of 26-31 SHALL produce input_char_eq_word = 0.
REQ-007 Repeated letters SHALL set every matching bit (e.g. CLOCK with C -> 5'b01001).
REQ-008 On en_guessed_letters=1 with s_guessed_letters=1, the mask SHALL become mask | input_char_eq_word, using the register value held before the edge.
REQ-009 On en_guessed_letters=1 with s_guessed_letters=0, the mask SHALL clear to 0.
REQ-010 guessed_letters_is_done SHALL equal (guessed_mask == 5'b11111), combinationally.
REQ-011 On en_tries=1, the tries counter SHALL load 6 when s_tries=1; when s_tries=0 it SHALL decrement, saturating at 0 (no wrap).
REQ-012 tries_zero SHALL equal (tries_left == 0).
REQ-013 On en_word_index=1, word_index SHALL increment, wrapping 7 -> 0.
REQ-014 win SHALL load s_win on en_win=1, and lose SHALL load s_lose on en_lose=1; both SHALL hold otherwise.
REQ-015 The registers SHALL be independent: any combination of enables asserted in the same cycle SHALL update every enabled register from pre-edge values.
REQ-016 When en_input_char and en_guessed_letters (s=1) coincide, the mask SHALL use the old char.
REQ-017 When en_word_index and en_guessed_letters (s=1) coincide, the mask SHALL use the old word.
REQ-018 With no enable asserted, every register SHALL hold its value.

Reset
REQ-019 When rst_n=0 at a clock edge, the block SHALL set: input-char register 5'h1F, input_char_eq_word 0, guessed_mask 0, guessed_letters_is_done 0, tries_left 6, tries_zero 0, word_index 0, win 0, lose 0.
REQ-020 Reset SHALL override all enables in the same cycle.
REQ-021 Reset asserted mid-game SHALL discard all game state in one edge.
REQ-022 Reset SHALL have no asynchronous effect: outputs change only on a clock edge.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then load char C (2) on word 0 -> input_char_eq_word = 5'b00001; en_guessed s=1 -> guessed_mask = 5'b00001.
- Load H, I, P, S (7, 8, 15, 18) on word 0, each followed by a mask update -> guessed_mask = 5'b11111 and guessed_letters_is_done = 1.
- Advance word_index to 5 and load C -> input_char_eq_word = 5'b01001; load code 27 -> 5'b00000.
- Seven decrements from 6 -> tries_left steps 5,4,3,2,1,0,0 with tries_zero = 1 at the last two; s_tries=1 reloads 6.
- Eight en_word_index pulses -> word_index 1..7 then 0.
- Mid-game with mask 5'b10110, tries 2, win=1, and all enables high together with rst_n=0 -> every reset value of REQ-019 holds the next cycle.
